// File: rtl/morse_receiver.sv
// morse_receiver: decodes a keyed Morse line into ASCII character strobes.
// The key is synchronized, timed in Morse units by a prescaler, classified
// into dots and dashes, and looked up as ITU letters/digits; long gaps
// produce a word-space character.
// Optional build macro MORSE_RX_DEBOUNCE_EN inserts a debounce stage after
// the synchronizer (DEBOUNCE_CYCLES is only used when it is defined).
module morse_receiver #(
    parameter int UNIT_CYCLES     = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY,
    output logic [7:0] CHAR_OUT,
    output logic       CHAR_VALID,
    output logic       ERR,
    output logic       RX_ACTIVE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

    localparam logic [27:0] UNIT_LAST = 28'(UNIT_CYCLES - 1);

    logic        key_meta;
    logic        key_sync;
    logic        ks;
    logic        ks_prev;
    logic        ks_edge;
    logic        rise;
    logic        fall;
    logic        tick;
    logic [27:0] presc_q;
    logic [27:0] phase;
    logic [3:0]  dur_q;
    state_t      state_q;
    state_t      state_d;
    logic [2:0]  len_q;
    logic [2:0]  len_d;
    logic [4:0]  code_q;
    logic [4:0]  code_d;
    logic        ovf_q;
    logic        ovf_d;
    logic        word_pend_q;
    logic        word_pend_d;
    logic [7:0]  char_q;
    logic [7:0]  char_d;
    logic        valid_q;
    logic        valid_d;
    logic        err_q;
    logic        err_d;
    logic [7:0]  lut_char;

    // Two-flop synchronizer bringing the asynchronous key into the clock domain
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
        end else begin
            key_meta <= KEY;
            key_sync <= key_meta;
        end
    end

`ifdef MORSE_RX_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt;
    logic            db_level;

    // Accept a new key level only once it has held for DEBOUNCE_CYCLES cycles
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (key_sync == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            db_level <= key_sync;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign ks = db_level;
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = (DEBOUNCE_CYCLES != 0);
    assign ks = key_sync;
`endif

    // Previous key level, used to spot rising and falling edges
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ks_prev <= 1'b0;
        end else begin
            ks_prev <= ks;
        end
    end

    assign ks_edge = ks ^ ks_prev;
    assign rise    = ks_edge & ks;
    assign fall    = ks_edge & ~ks;

    // The edge cycle itself counts as cycle 0 of a unit, so a level held for
    // exactly N units sees N ticks before the next edge arrives.
    assign phase = ks_edge ? 28'd0 : presc_q;
    assign tick  = (phase == UNIT_LAST);

    // Unit-time prescaler, restarted by every key edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q <= 28'd0;
        end else if (tick) begin
            presc_q <= 28'd0;
        end else begin
            presc_q <= phase + 28'd1;
        end
    end

    // Saturating count of whole units the current level has lasted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dur_q <= 4'd0;
        end else if (ks_edge) begin
            dur_q <= 4'd0;
        end else if (tick && (state_q != IDLE) && (dur_q != 4'd15)) begin
            dur_q <= dur_q + 4'd1;
        end
    end

    // ITU Morse table; the first symbol sits in the MSB of the used code bits
    function automatic logic [7:0] lookup(input logic [2:0] len, input logic [4:0] code);
        logic [7:0] ch;
        ch = 8'h3F;
        case ({len, code})
            {3'd1, 5'b00000}: ch = "E";
            {3'd1, 5'b00001}: ch = "T";
            {3'd2, 5'b00000}: ch = "I";
            {3'd2, 5'b00001}: ch = "A";
            {3'd2, 5'b00010}: ch = "N";
            {3'd2, 5'b00011}: ch = "M";
            {3'd3, 5'b00000}: ch = "S";
            {3'd3, 5'b00001}: ch = "U";
            {3'd3, 5'b00010}: ch = "R";
            {3'd3, 5'b00011}: ch = "W";
            {3'd3, 5'b00100}: ch = "D";
            {3'd3, 5'b00101}: ch = "K";
            {3'd3, 5'b00110}: ch = "G";
            {3'd3, 5'b00111}: ch = "O";
            {3'd4, 5'b00000}: ch = "H";
            {3'd4, 5'b00001}: ch = "V";
            {3'd4, 5'b00010}: ch = "F";
            {3'd4, 5'b00100}: ch = "L";
            {3'd4, 5'b00110}: ch = "P";
            {3'd4, 5'b00111}: ch = "J";
            {3'd4, 5'b01000}: ch = "B";
            {3'd4, 5'b01001}: ch = "X";
            {3'd4, 5'b01010}: ch = "C";
            {3'd4, 5'b01011}: ch = "Y";
            {3'd4, 5'b01100}: ch = "Z";
            {3'd4, 5'b01101}: ch = "Q";
            {3'd5, 5'b11111}: ch = "0";
            {3'd5, 5'b01111}: ch = "1";
            {3'd5, 5'b00111}: ch = "2";
            {3'd5, 5'b00011}: ch = "3";
            {3'd5, 5'b00001}: ch = "4";
            {3'd5, 5'b00000}: ch = "5";
            {3'd5, 5'b10000}: ch = "6";
            {3'd5, 5'b11000}: ch = "7";
            {3'd5, 5'b11100}: ch = "8";
            {3'd5, 5'b11110}: ch = "9";
            default:          ch = 8'h3F;
        endcase
        return ch;
    endfunction

    assign lut_char = lookup(len_q, code_q);

    // Next-state logic: symbol assembly, character and word-space emission
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        code_d      = code_q;
        ovf_d       = ovf_q;
        word_pend_d = word_pend_q;
        char_d      = char_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                len_d  = 3'd0;
                code_d = 5'd0;
                ovf_d  = 1'b0;
                if (rise) begin
                    state_d = MARK;
                end
            end

            MARK: begin
                if (fall) begin
                    if (dur_q == 4'd0) begin
                        state_d = (len_q != 3'd0) ? SPACE : IDLE;
                    end else begin
                        state_d = SPACE;
                        if (len_q == 3'd5) begin
                            ovf_d = 1'b1;
                        end else begin
                            code_d = {code_q[3:0], (dur_q >= 4'd2)};
                            len_d  = len_q + 3'd1;
                        end
                    end
                end
            end

            SPACE: begin
                if (rise) begin
                    state_d = MARK;
                end else if (tick && (dur_q == 4'd2) && (len_q != 3'd0)) begin
                    valid_d     = 1'b1;
                    char_d      = ovf_q ? 8'h3F : lut_char;
                    err_d       = ovf_q | (lut_char == 8'h3F);
                    len_d       = 3'd0;
                    code_d      = 5'd0;
                    ovf_d       = 1'b0;
                    word_pend_d = 1'b1;
                end else if (tick && (dur_q == 4'd6)) begin
                    if (word_pend_q) begin
                        valid_d = 1'b1;
                        char_d  = 8'h20;
                    end
                    word_pend_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, outputs registered for one-cycle latency
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            len_q       <= 3'd0;
            code_q      <= 5'd0;
            ovf_q       <= 1'b0;
            word_pend_q <= 1'b0;
            char_q      <= 8'h00;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            code_q      <= code_d;
            ovf_q       <= ovf_d;
            word_pend_q <= word_pend_d;
            char_q      <= char_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign CHAR_OUT   = char_q;
    assign CHAR_VALID = valid_q;
    assign ERR        = err_q;
    assign RX_ACTIVE  = (state_q != IDLE);

endmodule

// File: tb/tb_morse_receiver.sv
// tb_morse_receiver: drives Morse key waveforms into morse_receiver and
// checks every strobe against a Morse-level model of the expected text.
module tb_morse_receiver;

    localparam int UNIT = 4;
`ifdef MORSE_RX_DEBOUNCE_EN
    localparam int DB = 3;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = 2 + DB;

    typedef struct {
        int         cyc;
        logic [7:0] ch;
        logic       err;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       key;
    logic [7:0] char_out;
    logic       char_valid;
    logic       err;
    logic       rx_active;

    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    int    err_count = 0;
    string seen = "";
    exp_t  exp_q[$];

    string model_pattern = "";
    bit    model_active = 1'b0;
    bit    model_word_pend = 1'b0;

    string tab_code [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....",
        "--...", "---..", "----."
    };
    string tab_chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    morse_receiver #(
        .UNIT_CYCLES(UNIT),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .CLK(clock),
        .RST(reset),
        .KEY(key),
        .CHAR_OUT(char_out),
        .CHAR_VALID(char_valid),
        .ERR(err),
        .RX_ACTIVE(rx_active)
    );

    // Free-running clock and cycle index
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkText(input string name, input string expected);
        tests++;
        if (seen != expected) begin
            fails++;
            $display("[TB] FAIL %s: got \"%s\", expected \"%s\"", name, seen, expected);
        end
        seen = "";
    endtask

    function automatic void lookupModel(input string pat, output logic [7:0] ch, output logic e);
        ch = 8'h3F;
        e  = 1'b1;
        for (int i = 0; i < 36; i++) begin
            if (tab_code[i] == pat) begin
                ch = tab_chars.getc(i);
                e  = 1'b0;
            end
        end
    endfunction

    // Morse-level model: marks become dots/dashes, gaps of 3 and 7 units
    // end characters and words; strobes are scheduled relative to the key edge.
    task automatic modelSegment(input logic level, input int ncyc, input int t0);
        int         units;
        logic [7:0] ch;
        logic       e;
        units = ncyc / UNIT;
        if (level) begin
            if (ncyc < DB) return;
            if (units == 0) begin
                if (model_pattern.len() == 0) model_active = 1'b0;
            end else begin
                model_active = 1'b1;
                if (units >= 2) model_pattern = {model_pattern, "-"};
                else            model_pattern = {model_pattern, "."};
            end
        end else if (model_active) begin
            if (model_pattern.len() > 0 && units >= 3) begin
                lookupModel(model_pattern, ch, e);
                exp_q.push_back('{cyc: t0 + LAT + 3 * UNIT, ch: ch, err: e});
                model_pattern   = "";
                model_word_pend = 1'b1;
            end
            if (units >= 7) begin
                if (model_word_pend)
                    exp_q.push_back('{cyc: t0 + LAT + 7 * UNIT, ch: 8'h20, err: 1'b0});
                model_word_pend = 1'b0;
                model_active    = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input logic level, input int ncyc);
        key = level;
        modelSegment(level, ncyc, cyc);
        repeat (ncyc) @(posedge clock);
        #1;
    endtask

    // Compare every strobe (and every missing strobe) against the model queue
    always @(negedge clock) begin
        if (!reset) begin
            if (char_valid) begin
                seen = $sformatf("%s%c", seen, char_out);
                if (err) err_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_strobe_at_cycle", cyc, -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("strobe_cycle", cyc, e.cyc);
                    checkOutput("strobe_char", int'(char_out), int'(e.ch));
                    checkOutput("strobe_err", int'(err), int'(e.err));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checkOutput("missed_strobe_cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (err && !char_valid) checkOutput("err_without_valid", 1, 0);
        end
    end

    initial begin
        bit active_seen;
        key   = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_char_out", int'(char_out), 8'h00);
        checkOutput("reset_char_valid", int'(char_valid), 0);
        checkOutput("reset_err", int'(err), 0);
        checkOutput("reset_rx_active", int'(rx_active), 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Single dot then long gap: letter E followed by a word space
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 40);
        checkText("decode_E", "E ");
        checkOutput("idle_after_word", int'(rx_active), 0);

        // Dot, dash: A
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 40);
        checkText("decode_A", "A ");

        // T then O separated by a 3-unit gap, no word space between them
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 12);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 12);
            applyStimulus(1'b0, 4);
        end
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 40);
        checkText("decode_TO", "TO ");

        // Five dashes: digit 0
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 12);
            applyStimulus(1'b0, 4);
        end
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 40);
        checkText("decode_0", "0 ");

        // Six dots overflow the code register: '?' with ERR
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4);
            applyStimulus(1'b0, 4);
        end
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 40);
        checkText("decode_overflow", "? ");
        checkOutput("overflow_err_count", err_count, 1);

        // S with a sub-unit glitch between the first two dots
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 40);
        checkText("decode_S_glitch", "S ");

        // Mark longer than the duration counter range is still a dash
        applyStimulus(1'b1, 70);
        applyStimulus(1'b0, 40);
        checkText("decode_long_dash", "T ");

`ifdef MORSE_RX_DEBOUNCE_EN
        // A pulse shorter than the debounce window never reaches the decoder
        active_seen = 1'b0;
        key = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        key = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (rx_active) active_seen = 1'b1;
        end
        @(posedge clock);
        #1;
        checkOutput("debounce_drops_pulse", int'(active_seen), 0);
        checkText("debounce_no_strobe", "");
`else
        active_seen = 1'b0;
`endif

        // Reset in the middle of the third dash of '0' discards everything
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 4);
        key = 1'b1;
        repeat (6) @(posedge clock);
        #3;
        checkOutput("active_before_reset", int'(rx_active), 1);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_char_out", int'(char_out), 8'h00);
        checkOutput("async_reset_char_valid", int'(char_valid), 0);
        checkOutput("async_reset_err", int'(err), 0);
        checkOutput("async_reset_rx_active", int'(rx_active), 0);
        key = 1'b0;
        exp_q.delete();
        model_pattern   = "";
        model_active    = 1'b0;
        model_word_pend = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (80) @(posedge clock);
        #1;
        checkText("no_strobe_after_reset", "");
        checkOutput("idle_after_reset", int'(rx_active), 0);

        checkOutput("pending_strobes", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
